// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter feeding a single Wishbone-to-AHB bridge port.
// Grants are held for a whole CYC; a per-access watchdog turns hung accesses into errors.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic [2:0]  m0_wb_cti_i,
  input  logic [1:0]  m0_wb_bte_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  output logic [31:0] m0_wb_dat_o,

  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic [2:0]  m1_wb_cti_i,
  input  logic [1:0]  m1_wb_bte_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] m1_wb_dat_o,

  output logic [31:0] s_wb_adr_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic [31:0] s_wb_dat_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic [2:0]  s_wb_cti_o,
  output logic [1:0]  s_wb_bte_o,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  input  logic [31:0] s_wb_dat_i,

  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    GrNone = 2'b00,
    GrM0   = 2'b01,
    GrM1   = 2'b10
  } grant_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam bit               WdEn       = (TIMEOUT != 0);

  grant_e           g_q, g_d;
  logic             lo_q, lo_d;
  logic [CNT_W-1:0] wd_q, wd_d;

  logic owner_cyc;
  logic owner_stb;
  logic wd_hit;
  logic wd_err;

  always_comb begin
    owner_cyc = ((g_q == GrM0) & m0_wb_cyc_i) | ((g_q == GrM1) & m1_wb_cyc_i);
    owner_stb = ((g_q == GrM0) & m0_wb_stb_i) | ((g_q == GrM1) & m1_wb_stb_i);
  end

  // Re-arbitrate whenever the bus is free or the owner just dropped CYC, so handover is
  // back-to-back. lo_q names the last owner; the other master wins a tie.
  always_comb begin
    g_d  = g_q;
    lo_d = lo_q;
    if (!owner_cyc) begin
      unique case ({m1_wb_cyc_i, m0_wb_cyc_i})
        2'b01:   g_d = GrM0;
        2'b10:   g_d = GrM1;
        2'b11:   g_d = lo_q ? GrM0 : GrM1;
        default: g_d = GrNone;
      endcase
      if (g_d != GrNone) begin
        lo_d = (g_d == GrM1);
      end
    end
  end

  // A late ACK in the timeout cycle beats the watchdog, which puts s_wb_ack_i on a
  // combinational path to s_wb_stb_o.
  always_comb begin
    wd_hit = WdEn && owner_stb && (wd_q == TimeoutVal);
    wd_err = wd_hit && !s_wb_ack_i;
    if (!WdEn || !owner_stb || s_wb_ack_i || s_wb_err_i || wd_hit) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + CNT_W'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      g_q  <= GrNone;
      lo_q <= 1'b1;
      wd_q <= '0;
    end else begin
      g_q  <= g_d;
      lo_q <= lo_d;
      wd_q <= wd_d;
    end
  end

  always_comb begin
    s_wb_adr_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = 1'b0;
    s_wb_dat_o = '0;
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_cti_o = '0;
    s_wb_bte_o = '0;
    unique case (g_q)
      GrM0: begin
        s_wb_adr_o = m0_wb_adr_i;
        s_wb_sel_o = m0_wb_sel_i;
        s_wb_we_o  = m0_wb_we_i;
        s_wb_dat_o = m0_wb_dat_i;
        s_wb_cyc_o = m0_wb_cyc_i;
        s_wb_stb_o = m0_wb_stb_i & ~wd_err;
        s_wb_cti_o = m0_wb_cti_i;
        s_wb_bte_o = m0_wb_bte_i;
      end
      GrM1: begin
        s_wb_adr_o = m1_wb_adr_i;
        s_wb_sel_o = m1_wb_sel_i;
        s_wb_we_o  = m1_wb_we_i;
        s_wb_dat_o = m1_wb_dat_i;
        s_wb_cyc_o = m1_wb_cyc_i;
        s_wb_stb_o = m1_wb_stb_i & ~wd_err;
        s_wb_cti_o = m1_wb_cti_i;
        s_wb_bte_o = m1_wb_bte_i;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    m0_wb_ack_o = (g_q == GrM0) & s_wb_ack_i;
    m0_wb_err_o = (g_q == GrM0) & (s_wb_err_i | wd_err);
    m1_wb_ack_o = (g_q == GrM1) & s_wb_ack_i;
    m1_wb_err_o = (g_q == GrM1) & (s_wb_err_i | wd_err);
  end

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign grant_o     = g_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios then random traffic, all checked against
// an owner/last-owner/wait-count model of the arbitration and watchdog rules.
module tb_wb_master_arbiter;

  localparam int T = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;

  logic [31:0] adr[2];
  logic [3:0]  sel[2];
  logic        we[2];
  logic [31:0] wdat[2];
  logic        cyc[2];
  logic        stb[2];
  logic [2:0]  cti[2];
  logic [1:0]  bte[2];
  logic        ack[2];
  logic        err[2];
  logic [31:0] rdat[2];

  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb, s_ack, s_err;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  grant_o;

  int total = 0;
  int bad   = 0;

  // Model state: current owner (-1 none), last owner, cycles the owner's STB has waited.
  int owner = -1;
  int last  = 1;
  int wcnt  = 0;

  wb_master_arbiter #(.TIMEOUT(T), .CNT_W(8)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .m0_wb_adr_i (adr[0]),
    .m0_wb_sel_i (sel[0]),
    .m0_wb_we_i  (we[0]),
    .m0_wb_dat_i (wdat[0]),
    .m0_wb_cyc_i (cyc[0]),
    .m0_wb_stb_i (stb[0]),
    .m0_wb_cti_i (cti[0]),
    .m0_wb_bte_i (bte[0]),
    .m0_wb_ack_o (ack[0]),
    .m0_wb_err_o (err[0]),
    .m0_wb_dat_o (rdat[0]),
    .m1_wb_adr_i (adr[1]),
    .m1_wb_sel_i (sel[1]),
    .m1_wb_we_i  (we[1]),
    .m1_wb_dat_i (wdat[1]),
    .m1_wb_cyc_i (cyc[1]),
    .m1_wb_stb_i (stb[1]),
    .m1_wb_cti_i (cti[1]),
    .m1_wb_bte_i (bte[1]),
    .m1_wb_ack_o (ack[1]),
    .m1_wb_err_o (err[1]),
    .m1_wb_dat_o (rdat[1]),
    .s_wb_adr_o  (s_adr),
    .s_wb_sel_o  (s_sel),
    .s_wb_we_o   (s_we),
    .s_wb_dat_o  (s_wdat),
    .s_wb_cyc_o  (s_cyc),
    .s_wb_stb_o  (s_stb),
    .s_wb_cti_o  (s_cti),
    .s_wb_bte_o  (s_bte),
    .s_wb_ack_i  (s_ack),
    .s_wb_err_i  (s_err),
    .s_wb_dat_i  (s_rdat),
    .grant_o     (grant_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit();
    if (owner < 0) return 1'b0;
    return stb[owner] && (wcnt == T);
  endfunction

  task automatic check_outputs();
    logic [31:0] e_adr, e_wdat;
    logic [11:0] e_ctl;
    logic [1:0]  e_gnt;
    logic [3:0]  e_rsp;
    bit          werr;
    werr  = m_hit() && !s_ack;
    e_adr = '0;
    e_wdat = '0;
    e_ctl = '0;
    e_gnt = '0;
    e_rsp = '0;
    if (owner >= 0) begin
      e_adr  = adr[owner];
      e_wdat = wdat[owner];
      e_ctl  = {sel[owner], we[owner], cti[owner], bte[owner], cyc[owner],
                stb[owner] && !werr};
      e_gnt  = (owner == 0) ? 2'b01 : 2'b10;
      e_rsp[owner*2 +: 2] = {s_ack, s_err || werr};
    end
    chk("grant", {30'd0, grant_o}, {30'd0, e_gnt});
    chk("s_adr", s_adr, e_adr);
    chk("s_dat", s_wdat, e_wdat);
    chk("s_ctl", {20'd0, s_sel, s_we, s_cti, s_bte, s_cyc, s_stb}, {20'd0, e_ctl});
    chk("rsp", {28'd0, ack[1], err[1], ack[0], err[0]}, {28'd0, e_rsp});
    chk("m0_dat", rdat[0], s_rdat);
    chk("m1_dat", rdat[1], s_rdat);
  endtask

  task automatic advance();
    int nxt;
    if (owner < 0 || !stb[owner] || s_ack || s_err || m_hit()) wcnt = 0;
    else wcnt++;
    if (owner < 0 || !cyc[owner]) begin
      if (cyc[0] && cyc[1]) nxt = 1 - last;
      else if (cyc[0])      nxt = 0;
      else if (cyc[1])      nxt = 1;
      else                  nxt = -1;
      owner = nxt;
      if (nxt >= 0) last = nxt;
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1;
    wcnt  = 0;
  endtask

  // Check this cycle's outputs, then step model and DUT across one clock edge.
  task automatic cycle();
    #1;
    check_outputs();
    advance();
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input int i, input logic [31:0] a, input logic [2:0] c);
    cyc[i] = 1'b1;
    stb[i] = 1'b1;
    adr[i] = a;
    cti[i] = c;
  endtask

  task automatic drop(input int i);
    cyc[i] = 1'b0;
    stb[i] = 1'b0;
    cti[i] = 3'b000;
  endtask

  initial begin
    int cur;
    for (int i = 0; i < 2; i++) begin
      adr[i] = 32'h100 * (i + 1);
      sel[i] = 4'hF;
      we[i] = 1'(i);
      wdat[i] = 32'hC0DE_0000 + i;
      cyc[i] = 1'b1;
      stb[i] = 1'b1;
      cti[i] = '0;
      bte[i] = '0;
    end
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rdat = 32'hA5A5_0001;

    // Reset held with both masters requesting: nothing may be granted.
    @(posedge HCLK);
    #1;
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_cyc_stb", {30'd0, s_cyc, s_stb}, 32'd0);
    chk("rst_rsp", {28'd0, ack[1], err[1], ack[0], err[0]}, 32'd0);
    chk("rst_m0_dat", rdat[0], 32'hA5A5_0001);
    chk("rst_m1_dat", rdat[1], 32'hA5A5_0001);
    drop(0);
    drop(1);
    HRESETn = 1'b1;

    // Tie after reset: m0 first, then m1 takes over at the edge m0 drops CYC.
    req(0, 32'h0000_2000, 3'b000);
    req(1, 32'h0000_3000, 3'b000);
    cycle();
    #1 chk("tie_m0_first", {30'd0, grant_o}, 32'h1);
    s_ack = 1'b1;
    cycle();
    drop(0);
    s_ack = 1'b0;
    cycle();
    #1 chk("handover_m1", {30'd0, grant_o}, 32'h2);
    s_ack = 1'b1;
    cycle();
    drop(1);
    s_ack = 1'b0;
    cycle();

    // Single m0 read.
    req(0, 32'h0000_1000, 3'b000);
    we[0] = 1'b0;
    #1 chk("m0_not_yet", {31'd0, s_cyc}, 32'd0);
    cycle();
    #1 chk("m0_cyc", {31'd0, s_cyc}, 32'd1);
    chk("m0_adr", s_adr, 32'h0000_1000);
    s_ack = 1'b1;
    s_rdat = 32'hDEAD_BEEF;
    #1 chk("m0_ack", {31'd0, ack[0]}, 32'd1);
    chk("m0_rdat", rdat[0], 32'hDEAD_BEEF);
    chk("m1_no_ack", {31'd0, ack[1]}, 32'd0);
    cycle();
    drop(0);
    s_ack = 1'b0;
    cycle();

    // m1 4-beat incrementing burst; m0 waits until m1 releases.
    req(1, 32'h0000_4000, 3'b010);
    cycle();
    req(0, 32'h0000_5000, 3'b000);
    for (int b = 0; b < 4; b++) begin
      cti[1] = (b == 3) ? 3'b111 : 3'b010;
      adr[1] = 32'h0000_4000 + 32'(4 * b);
      s_ack = 1'b1;
      #1 chk("burst_owner", {30'd0, grant_o}, 32'h2);
      chk("burst_acks", {30'd0, ack[1], ack[0]}, 32'h2);
      cycle();
    end
    drop(1);
    s_ack = 1'b0;
    #1 chk("burst_release", {30'd0, grant_o}, 32'h2);
    cycle();
    #1 chk("m0_after_burst", {30'd0, grant_o}, 32'h1);
    s_ack = 1'b1;
    cycle();
    drop(0);
    s_ack = 1'b0;
    cycle();

    // Continuous requests from both masters: ownership alternates, m1 first (m0 was last).
    req(0, 32'h0000_6000, 3'b000);
    req(1, 32'h0000_7000, 3'b000);
    cycle();
    for (int k = 0; k < 8; k++) begin
      cur = ((k / 2) % 2 == 0) ? 1 : 0;
      cyc[cur] = (k % 2 == 0);
      stb[cur] = (k % 2 == 0);
      cyc[1 - cur] = 1'b1;
      stb[1 - cur] = 1'b1;
      s_ack = (k % 2 == 0);
      #1 chk("rr_grant", {30'd0, grant_o}, (cur == 0) ? 32'h1 : 32'h2);
      cycle();
    end
    drop(0);
    drop(1);
    s_ack = 1'b0;
    cycle();
    cycle();

    // Watchdog with no response: one error pulse, STB masked in that cycle.
    req(0, 32'h0000_8000, 3'b000);
    cycle();
    for (int j = 1; j <= T; j++) begin
      #1 chk("wd_wait_err", {31'd0, err[0]}, 32'd0);
      chk("wd_wait_stb", {31'd0, s_stb}, 32'd1);
      cycle();
    end
    #1 chk("wd_err", {31'd0, err[0]}, 32'd1);
    chk("wd_stb_mask", {30'd0, s_cyc, s_stb}, 32'h2);
    cycle();
    drop(0);
    #1 chk("wd_err_once", {31'd0, err[0]}, 32'd0);
    cycle();
    cycle();

    // ACK lands in the timeout cycle: ACK only.
    req(0, 32'h0000_9000, 3'b000);
    cycle();
    for (int j = 1; j <= T; j++) cycle();
    s_ack = 1'b1;
    #1 chk("wd_ack_wins", {30'd0, ack[0], err[0]}, 32'h2);
    cycle();
    s_ack = 1'b0;
    drop(0);
    cycle();
    cycle();

    // Asynchronous reset in the middle of an m1 burst.
    req(1, 32'h0000_A000, 3'b010);
    cycle();
    s_ack = 1'b1;
    cycle();
    cycle();
    HRESETn = 1'b0;
    #1 chk("arst_bus", {29'd0, grant_o, s_cyc | s_stb}, 32'd0);
    chk("arst_ack", {31'd0, ack[1]}, 32'd0);
    model_reset();
    s_ack = 1'b0;
    @(posedge HCLK);
    #1 chk("arst_hold", {30'd0, grant_o}, 32'd0);
    req(0, 32'h0000_B000, 3'b000);
    HRESETn = 1'b1;
    cycle();
    #1 chk("arst_tie_m0", {30'd0, grant_o}, 32'h1);
    s_ack = 1'b1;
    cycle();
    drop(0);
    s_ack = 1'b0;
    cycle();
    drop(1);
    cycle();
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (cyc[i]) begin
          if ($urandom_range(3) == 0) cyc[i] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          cyc[i] = 1'b1;
        end
        stb[i]  = cyc[i] & ($urandom_range(3) != 0);
        adr[i]  = $urandom;
        wdat[i] = $urandom;
        sel[i]  = 4'($urandom);
        we[i]   = 1'($urandom);
        cti[i]  = 3'($urandom);
        bte[i]  = 2'($urandom);
      end
      s_ack  = ($urandom_range(5) == 0);
      s_err  = !s_ack && ($urandom_range(15) == 0);
      s_rdat = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
